shift_normalizer: RTL and testbench
===================================

Name: shift_normalizer

Overview:
- Multi-cycle normalize / leading-count unit: the inverse of the datapath funnel shifter.
- Given a 32-bit operand, it finds the shift amount that left-justifies the operand (or right-justifies it for CTZ), returns that amount, and returns the normalized operand.
- Serves the bit-manipulation path (clz/ctz/cls) and the soft-float normalize step.
- Sits beside the ALU, behind valid/ready handshakes on both sides.

Parameters:
- STEPS, 5: search steps, one per shift-amount bit (log2 of 32). Fixed; kept as a parameter for the assertion only.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  operand valid
- in_ready  out  1  unit can accept an operand
- a  in  32  operand
- f  in  2  mode: 00 CLZ, 01 CTZ, 10 CLZ (reserved alias), 11 CLS (redundant sign bits)
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- count  out  6  shift amount, 0..32
- y  out  32  normalized operand
- zero  out  1  operand was all-zero (CLZ/CTZ) or all-sign (CLS)

Behaviour:
- Interface (already decided): one clock `clk`; reset `reset` is synchronous and active-high.
- Reset values: in_ready=1, out_valid=0, count=0, y=0, zero=0, FSM=IDLE. Reset wins over every other event, including mid-BUSY and while out_valid is high; any in-flight result is discarded.
- FSM states: IDLE, BUSY, DONE.
  - IDLE: in_ready=1. A handshake (in_valid & in_ready) latches a and f into the work registers, clears the count accumulator, sets step=4, and moves to BUSY.
  - BUSY: in_ready=0. Each cycle resolves one count bit, in order 16, 8, 4, 2, 1 (w=2^step).
    - CLZ: if work[31:32-w]==0, then work<<=w and count+=w.
    - CTZ: if work[w-1:0]==0, then work>>=w and count+=w.
    - CLS: if work[31:31-w] all equal, then work<<=w (zero fill) and count+=w.
    - After step 0 the FSM goes to DONE.
- Zero / all-sign handling (evaluated at the transition to DONE):
  - CLZ/CTZ: if the final work value is 0, then count=32, zero=1, y=0.
  - CLS: if the operand was all-0 or all-1, then count=31, zero=1, y = work (i.e. a<<31).
  - Otherwise zero=0, count = accumulated value (0..31), y = final work.
- DONE: out_valid=1. count, y and zero are held stable until out_ready. A handshake returns the FSM to IDLE; in_ready rises the cycle after the handshake. No overlap between operations; peak throughput is 1 operation per 7 cycles.
- Latency: out_valid is asserted 6 cycles after the input handshake edge (1 load, 5 steps; the DONE register is written on the step-0 edge).
- Backpressure: DONE holds indefinitely. in_valid seen in BUSY/DONE is ignored; the producer keeps it asserted.
- f=10 behaves exactly as 00.
- Width rules: the count accumulator is 6 bits with no overflow, because the maximum sum of steps is 31 plus the zero fix-up to 32.

Optional Feature:
- Macro: SHIFT_NORMALIZER_EARLY_EXIT_EN.
- When defined, IDLE examines the operand on the accept cycle and jumps straight to DONE (out_valid 1 cycle after handshake) in three cases:
  - a==0 with CLZ/CTZ: count=32, zero=1.
  - count is trivially 0: CLZ with a[31]=1, CTZ with a[0]=1, or CLS with a[31]!=a[30]. Result is count=0, y=a.
  - All other operands take the 6-cycle path.
- When undefined, every operand takes 6 cycles. Results are identical in both builds; only latency differs.

Decomposition:
- Package shift_normalizer_pkg contains:
  - enum norm_mode_e (CLZ=2'b00, CTZ=2'b01, CLS=2'b11)
  - enum norm_state_e (IDLE, BUSY, DONE)
  - constants XLEN=32 and CNT_W=6
- One natural sub-module, norm_step: combinational. Inputs are work, mode and step index; outputs are next work and the taken bit. The top instantiates it once and steps it sequentially.

Test Plan:
- a=0x0000_F000, f=00 -> count=16, y=0xF000_0000, zero=0, out_valid 6 cycles after accept.
- a=0x0000_0000, f=01 -> count=32, y=0, zero=1.
- a=0xFFFF_8123, f=11 -> count=16, y=0x8123_0000; then a=0xFFFF_FFFF, f=11 -> count=31, zero=1.
- a=0x0000_0100, f=01 with out_ready=0 for 10 cycles -> count=8 and y=0x1 held stable, in_ready=0 throughout; one cycle after the handshake in_ready=1.
- reset pulsed during BUSY step 2 (a=0x1, f=00) -> the next cycle has out_valid=0 and in_ready=1; a fresh a=0x1 returns count=31, y=0x8000_0000.
- With SHIFT_NORMALIZER_EARLY_EXIT_EN defined: a=0x8000_0000, f=00 -> count=0 with out_valid 1 cycle after accept. Same stimulus without the macro -> identical result at 6 cycles.

Source files
------------

// File: rtl/shift_normalizer_pkg.sv
// Shared types and constants for the shift_normalizer normalize / leading-count unit.
package shift_normalizer_pkg;
    localparam int XLEN  = 32;
    localparam int CNT_W = 6;

    typedef enum logic [1:0] {
        CLZ = 2'b00,
        CTZ = 2'b01,
        CLS = 2'b11
    } norm_mode_e;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } norm_state_e;

    // f=10 is a reserved alias of CLZ
    function automatic norm_mode_e decode_mode(input logic [1:0] f);
        norm_mode_e m;
        case (f)
            2'b01:   m = CTZ;
            2'b11:   m = CLS;
            default: m = CLZ;
        endcase
        return m;
    endfunction
endpackage

// File: rtl/shift_normalizer_step.sv
// One binary-search step: tests a 2^step wide window and shifts it out when it is redundant.
module norm_step
    import shift_normalizer_pkg::*;
(
    input  logic [XLEN-1:0] work,
    input  norm_mode_e      mode,
    input  logic [2:0]      step,
    output logic [XLEN-1:0] work_nxt,
    output logic            taken
);
    logic [XLEN-1:0] ones, hi_m, lo_m, sg_m, sg_bits;
    logic [5:0]      w;

    always_comb begin
        ones     = '1;
        w        = 6'd1 << step;
        hi_m     = ~(ones >> w);
        lo_m     = ~(ones << w);
        // CLS window includes the sign bit itself, so it is one bit wider
        sg_m     = ~(ones >> (w + 6'd1));
        sg_bits  = work & sg_m;
        taken    = 1'b0;
        work_nxt = work;
        case (mode)
            CTZ: begin
                taken    = (work & lo_m) == '0;
                work_nxt = taken ? (work >> w) : work;
            end
            CLS: begin
                taken    = (sg_bits == '0) || (sg_bits == sg_m);
                work_nxt = taken ? (work << w) : work;
            end
            default: begin
                taken    = (work & hi_m) == '0;
                work_nxt = taken ? (work << w) : work;
            end
        endcase
    end
endmodule

// File: rtl/shift_normalizer.sv
// Multi-cycle CLZ/CTZ/CLS normalizer, one count bit per cycle (16,8,4,2,1).
// Optional SHIFT_NORMALIZER_EARLY_EXIT_EN: zero and trivially-normalized operands skip the search.
module shift_normalizer
    import shift_normalizer_pkg::*;
#(
    parameter int STEPS = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [XLEN-1:0]  a,
    input  logic [1:0]       f,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] count,
    output logic [XLEN-1:0]  y,
    output logic             zero
);
    norm_state_e      state, state_n;
    norm_mode_e       mode;
    logic [XLEN-1:0]  work, step_work;
    logic [CNT_W-1:0] acc, inc, fin_cnt;
    logic [2:0]       step;
    logic             taken, accept, early, early_zero;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign accept    = in_valid & in_ready;

`ifdef SHIFT_NORMALIZER_EARLY_EXIT_EN
    norm_mode_e in_mode;
    logic       early_triv;
    always_comb begin
        in_mode    = decode_mode(f);
        early_zero = (in_mode != CLS) && (a == '0);
        early_triv = ((in_mode == CLZ) && a[XLEN-1]) ||
                     ((in_mode == CTZ) && a[0]) ||
                     ((in_mode == CLS) && (a[XLEN-1] != a[XLEN-2]));
        early      = early_zero | early_triv;
    end
`else
    assign early      = 1'b0;
    assign early_zero = 1'b0;
`endif

    norm_step u_step (
        .work     (work),
        .mode     (mode),
        .step     (step),
        .work_nxt (step_work),
        .taken    (taken)
    );

    always_comb begin
        inc     = taken ? (CNT_W'(1) << step) : '0;
        fin_cnt = acc + inc;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (accept) state_n = early ? DONE : BUSY;
            BUSY:    if (step == 3'd0) state_n = DONE;
            DONE:    if (out_ready) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            mode  <= CLZ;
            work  <= '0;
            acc   <= '0;
            step  <= '0;
            count <= '0;
            y     <= '0;
            zero  <= 1'b0;
        end else begin
            state <= state_n;
            case (state)
                IDLE: if (accept) begin
                    work <= a;
                    mode <= decode_mode(f);
                    acc  <= '0;
                    step <= 3'(STEPS - 1);
                    if (early) begin
                        count <= early_zero ? CNT_W'(XLEN) : '0;
                        y     <= a;
                        zero  <= early_zero;
                    end
                end
                BUSY: begin
                    work <= step_work;
                    acc  <= fin_cnt;
                    if (step != 3'd0) begin
                        step <= step - 3'd1;
                    end else if ((mode != CLS) && (step_work == '0)) begin
                        count <= CNT_W'(XLEN);
                        y     <= '0;
                        zero  <= 1'b1;
                    end else if ((mode == CLS) && (fin_cnt == CNT_W'(XLEN - 1))) begin
                        // the search only reaches 31 when every bit equals the sign
                        count <= CNT_W'(XLEN - 1);
                        y     <= step_work;
                        zero  <= 1'b1;
                    end else begin
                        count <= fin_cnt;
                        y     <= step_work;
                        zero  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    a_step_range: assert property (@(posedge clk) disable iff (reset)
        (state == BUSY) |-> (32'(step) < STEPS));
endmodule

// File: tb/tb_shift_normalizer.sv
// Directed + random bench for shift_normalizer against a bit-counting reference model.
module tb_shift_normalizer;
    logic        clk = 1'b0;
    logic        reset, in_valid, in_ready, out_valid, out_ready, zero;
    logic [31:0] a, y;
    logic [1:0]  f;
    logic [5:0]  count;
    int          total = 0;
    int          bad = 0;
    logic [5:0]  last_cnt;
    logic [31:0] last_y;
    logic        last_z;
    int          last_lat;

    shift_normalizer dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .f(f), .out_valid(out_valid), .out_ready(out_ready),
        .count(count), .y(y), .zero(zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic void model(input logic [31:0] av, input logic [1:0] fv,
                                  output logic [5:0] c, output logic [31:0] yy,
                                  output logic z, output int lat);
        int n;
        n = 0;
        if (fv == 2'b11) begin
            while (n < 31 && av[30-n] == av[31]) n++;
            c  = 6'(n);
            yy = av << n;
            z  = (n == 31);
        end else if (av == 0) begin
            c = 6'd32; yy = 32'h0; z = 1'b1;
        end else if (fv == 2'b01) begin
            while (av[n] == 1'b0) n++;
            c = 6'(n); yy = av >> n; z = 1'b0;
        end else begin
            while (av[31-n] == 1'b0) n++;
            c = 6'(n); yy = av << n; z = 1'b0;
        end
`ifdef SHIFT_NORMALIZER_EARLY_EXIT_EN
        lat = (c == 0 || (fv != 2'b11 && av == 0)) ? 1 : 6;
`else
        lat = 6;
`endif
    endfunction

    task automatic wait_ready();
        int n;
        n = 0;
        while (in_ready !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
        check("accept_timeout", 64'(n < 50), 1);
    endtask

    task automatic run_op(input logic [31:0] av, input logic [1:0] fv, input int hold);
        logic [5:0]  ec;
        logic [31:0] ey;
        logic        ez;
        int          el, lat;
        model(av, fv, ec, ey, ez, el);
        a = av; f = fv; in_valid = 1'b1;
        wait_ready();
        @(posedge clk); #1;
        // producer keeps in_valid high with junk data while the unit is busy
        a = $urandom; f = 2'($urandom);
        lat = 1;
        while (out_valid !== 1'b1 && lat < 20) begin
            check("busy_in_ready", in_ready, 0);
            @(posedge clk); #1; lat++;
        end
        in_valid = 1'b0;
        check("latency", lat, el);
        check("count", count, ec);
        check("y", y, ey);
        check("zero", zero, ez);
        check("done_in_ready", in_ready, 0);
        last_cnt = count; last_y = y; last_z = zero; last_lat = lat;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check("hold_count", count, ec);
            check("hold_y", y, ey);
            check("hold_valid", out_valid, 1);
            check("hold_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("post_valid", out_valid, 0);
        check("post_in_ready", in_ready, 1);
    endtask

    task automatic reset_mid(input logic [31:0] av, input logic [1:0] fv, input int edges);
        a = av; f = fv; in_valid = 1'b1;
        wait_ready();
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (edges) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_count", count, 0);
        check("rst_y", y, 0);
        check("rst_zero", zero, 0);
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; f = '0;
        repeat (3) @(posedge clk);
        #1;
        check("init_in_ready", in_ready, 1);
        check("init_out_valid", out_valid, 0);
        check("init_count", count, 0);
        check("init_y", y, 0);
        check("init_zero", zero, 0);
        reset = 1'b0;

        run_op(32'h0000_F000, 2'b00, 0);
        check("tp_clz_cnt", last_cnt, 16);
        check("tp_clz_y", last_y, 32'hF000_0000);
        check("tp_clz_lat", last_lat, 6);
        run_op(32'h0000_0000, 2'b01, 0);
        check("tp_ctz0_cnt", last_cnt, 32);
        check("tp_ctz0_z", last_z, 1);
        run_op(32'hFFFF_8123, 2'b11, 0);
        check("tp_cls_cnt", last_cnt, 16);
        check("tp_cls_y", last_y, 32'h8123_0000);
        run_op(32'hFFFF_FFFF, 2'b11, 0);
        check("tp_cls1_cnt", last_cnt, 31);
        check("tp_cls1_z", last_z, 1);
        run_op(32'h0000_0100, 2'b01, 10);
        check("tp_ctz_cnt", last_cnt, 8);
        check("tp_ctz_y", last_y, 32'h1);
        run_op(32'h0000_0000, 2'b00, 0);
        run_op(32'h0000_0000, 2'b11, 0);
        run_op(32'h8000_0000, 2'b00, 0);
        check("tp_msb_cnt", last_cnt, 0);
        run_op(32'h0000_0001, 2'b10, 2);
        run_op(32'h0000_0001, 2'b01, 0);
        run_op(32'h4000_0000, 2'b11, 0);

        reset_mid(32'h0000_0001, 2'b00, 2);
        run_op(32'h0000_0001, 2'b00, 0);
        check("tp_rst_cnt", last_cnt, 31);
        check("tp_rst_y", last_y, 32'h8000_0000);
        reset_mid(32'h0000_00F0, 2'b11, 7);

        for (int k = 0; k < 40; k++) begin
            logic [31:0] r;
            case ($urandom_range(0, 3))
                0:       r = $urandom;
                1:       r = $urandom >> $urandom_range(0, 32);
                2:       r = $urandom << $urandom_range(0, 32);
                default: r = ~($urandom >> $urandom_range(0, 32));
            endcase
            run_op(r, 2'($urandom), $urandom_range(0, 2));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
